// File: rtl/trig_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trig_phase_sequencer
// Description : Trig expansion term generator for the FLAF datapath.
//               For every accepted sample x it produces sin(k*pi*x) and
//               cos(k*pi*x), k = 1..ORDER, one term at a time. A single
//               external quarter-wave LUT (65 entries, magnitudes with
//               0x8000 = 1.0) is folded to the full circle.
// Ports       : clk, rst             - clock, async active-high reset
//               in_valid/in_ready    - sample handshake, x_in (Q1.15)
//               lut_idx              - LUT index 0..64 (combinational)
//               lut_sin/lut_cos      - LUT magnitudes for lut_idx
//               out_valid/out_ready  - term handshake
//               out_sin/out_cos      - signed Q1.15 term values
//               out_k, out_last      - harmonic number, last-term flag
// Revision    : 1.0 - initial release
// ============================================================================
module trig_phase_sequencer #(
    parameter int ORDER = 3,
    parameter int KW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   x_in,
    output logic [6:0]    lut_idx,
    input  logic [15:0]   lut_sin,
    input  logic [15:0]   lut_cos,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_sin,
    output logic [15:0]   out_cos,
    output logic [KW-1:0] out_k,
    output logic          out_last
);

    localparam logic [KW-1:0] C_K_LAST = KW'(ORDER);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_phase;
    logic [15:0]   r_x;
    logic [KW-1:0] r_k;
    logic [15:0]   w_sin_fold;
    logic [15:0]   w_cos_fold;
    logic          w_is_last;

    // Positive magnitude: 1.0 is not representable in Q1.15, clip it.
    function automatic logic [15:0] pos_sat(input logic [15:0] m);
        return (m == 16'h8000) ? 16'h7FFF : m;
    endfunction

    // Negative magnitude: plain two's complement; 0x8000 maps onto -1.0.
    function automatic logic [15:0] neg_mag(input logic [15:0] m);
        return ~m + 16'd1;
    endfunction

    // (f + 128) >> 8 reduces to f[13:8] plus the rounding carry from f[7].
    assign lut_idx   = {1'b0, r_phase[13:8]} + {6'd0, r_phase[7]};
    assign w_is_last = (r_k == C_K_LAST);
    assign in_ready  = (r_state == S_IDLE) && !rst;

    // Quadrant fold of the first-quadrant LUT values.
    always_comb begin
        w_sin_fold = pos_sat(lut_sin);
        w_cos_fold = pos_sat(lut_cos);
        case (r_phase[15:14])
            2'd0: begin
                w_sin_fold = pos_sat(lut_sin);
                w_cos_fold = pos_sat(lut_cos);
            end
            2'd1: begin
                w_sin_fold = pos_sat(lut_cos);
                w_cos_fold = neg_mag(lut_sin);
            end
            2'd2: begin
                w_sin_fold = neg_mag(lut_sin);
                w_cos_fold = neg_mag(lut_cos);
            end
            default: begin
                w_sin_fold = neg_mag(lut_cos);
                w_cos_fold = pos_sat(lut_sin);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_state_nxt = S_LOOKUP;
            S_LOOKUP: w_state_nxt = S_EMIT;
            S_EMIT:   if (out_ready) w_state_nxt = w_is_last ? S_IDLE : S_LOOKUP;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase   <= 16'd0;
            r_x       <= 16'd0;
            r_k       <= '0;
            out_valid <= 1'b0;
            out_sin   <= 16'd0;
            out_cos   <= 16'd0;
            out_k     <= '0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= x_in;
                        r_phase <= x_in;
                        r_k     <= KW'(1);
                    end
                end
                S_LOOKUP: begin
                    out_sin   <= w_sin_fold;
                    out_cos   <= w_cos_fold;
                    out_k     <= r_k;
                    out_last  <= w_is_last;
                    out_valid <= 1'b1;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!w_is_last) begin
                            // Wrap-around add: phase stays k*x mod 2*pi.
                            r_phase <= r_phase + r_x;
                            r_k     <= r_k + KW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
